// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Sequencer for a two-digit BCD stopwatch / countdown datapath. It owns the
// IDLE/RUN/PAUSE/DONE state machine and the BCD count. It also drives one
// shared 7-segment decoder by alternating between the ones and tens digits.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   tick      one-cycle count enable from the slow divider (clk domain)
//   pb_start  raw start/pause button, asynchronous, active-high
//   pb_clear  raw clear button, asynchronous, active-high
//   sw_load   level, loads the tens preset while idle
//   sw_dir    0 = count up, 1 = count down (latched on start from IDLE)
//   preset    BCD tens preset, values above 9 clamp to 9
//   ones/tens BCD count
//   digit     digit currently routed to the shared decoder
//   en0/en1   ones/tens digit enables, exactly one high
//   running   high in RUN
//   done      high in DONE
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
   parameter int DEB_CYCLES = 4,
   parameter int MUX_DIV    = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       pb_start,
   input  logic       pb_clear,
   input  logic       sw_load,
   input  logic       sw_dir,
   input  logic [3:0] preset,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic [3:0] digit,
   output logic       en0,
   output logic       en1,
   output logic       running,
   output logic       done
);

   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Button path, index 0 = start, index 1 = clear
   logic [1:0]    sync1_r;
   logic [1:0]    sync2_r;
   logic [1:0]    deb_r;
   logic [1:0]    press_r;
   logic [DW-1:0] deb_cnt_r [2];

   logic          start_ev_s;
   logic          clear_ev_s;

   // FSM and count
   state_t        state_r;
   state_t        state_nx;
   logic [3:0]    ones_r;
   logic [3:0]    tens_r;
   logic [3:0]    ones_nx;
   logic [3:0]    tens_nx;
   logic          dir_r;
   logic          dir_nx;
   logic          running_r;
   logic          done_r;

   logic [3:0]    step_ones_s;
   logic [3:0]    step_tens_s;
   logic          at_term_s;
   logic          step_term_s;
   logic [3:0]    preset_clamp_s;

   // Digit scheduler
   logic [MW-1:0] mux_cnt_r;
   logic          slot_r;
   logic          slot_nx_s;
   logic          wrap_s;
   logic [3:0]    digit_r;
   logic          en0_r;
   logic          en1_r;

   // Two-flop synchronisers followed by counting debouncers. The press pulse
   // is registered in the same edge that flips the debounced level, so a clean
   // raw edge appears as a pulse 2+DEB_CYCLES cycles later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 2'b00;
         sync2_r <= 2'b00;
         deb_r   <= 2'b00;
         press_r <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            deb_cnt_r[i] <= '0;
         end
      end else begin
         sync1_r <= {pb_clear, pb_start};
         sync2_r <= sync1_r;
         for (int i = 0; i < 2; i++) begin
            if (sync2_r[i] != deb_r[i]) begin
               if (deb_cnt_r[i] == DW'(DEB_CYCLES - 1)) begin
                  deb_r[i]     <= sync2_r[i];
                  deb_cnt_r[i] <= '0;
                  press_r[i]   <= sync2_r[i];
               end else begin
                  deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
                  press_r[i]   <= 1'b0;
               end
            end else begin
               // any sample agreeing with the accepted level restarts the run
               deb_cnt_r[i] <= '0;
               press_r[i]   <= 1'b0;
            end
         end
      end
   end

   assign start_ev_s = press_r[0];
   assign clear_ev_s = press_r[1];

   assign preset_clamp_s = (preset > 4'd9) ? 4'd9 : preset;

   // One BCD step in the latched direction, plus terminal-value detection for
   // the current count and for the stepped count.
   always_comb begin
      step_ones_s = ones_r;
      step_tens_s = tens_r;
      if (dir_r) begin
         if (ones_r == 4'd0) begin
            step_ones_s = 4'd9;
            step_tens_s = tens_r - 4'd1;
         end else begin
            step_ones_s = ones_r - 4'd1;
         end
         at_term_s   = (ones_r == 4'd0) && (tens_r == 4'd0);
         step_term_s = (step_ones_s == 4'd0) && (step_tens_s == 4'd0);
      end else begin
         if (ones_r == 4'd9) begin
            step_ones_s = 4'd0;
            step_tens_s = tens_r + 4'd1;
         end else begin
            step_ones_s = ones_r + 4'd1;
         end
         at_term_s   = (ones_r == 4'd9) && (tens_r == 4'd9);
         step_term_s = (step_ones_s == 4'd9) && (step_tens_s == 4'd9);
      end
   end

   // Next-state and next-count decode; clear overrides everything else.
   always_comb begin
      state_nx = state_r;
      ones_nx  = ones_r;
      tens_nx  = tens_r;
      dir_nx   = dir_r;
      if (clear_ev_s) begin
         state_nx = ST_IDLE;
         ones_nx  = 4'd0;
         tens_nx  = 4'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (sw_load) begin
                  tens_nx = preset_clamp_s;
                  ones_nx = 4'd0;
               end else begin
                  tens_nx = tens_r;
               end
               if (start_ev_s) begin
                  dir_nx = sw_dir;
                  // a down count starting from 00 has nothing to do
                  if (sw_dir && (ones_nx == 4'd0) && (tens_nx == 4'd0)) begin
                     state_nx = ST_DONE;
                  end else begin
                     state_nx = ST_RUN;
                  end
               end else begin
                  state_nx = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (tick) begin
                  if (at_term_s) begin
                     state_nx = ST_DONE;
                  end else begin
                     ones_nx = step_ones_s;
                     tens_nx = step_tens_s;
                     // reaching the terminal value beats a simultaneous pause
                     if (step_term_s) begin
                        state_nx = ST_DONE;
                     end else if (start_ev_s) begin
                        state_nx = ST_PAUSE;
                     end else begin
                        state_nx = ST_RUN;
                     end
                  end
               end else if (start_ev_s) begin
                  state_nx = ST_PAUSE;
               end else begin
                  state_nx = ST_RUN;
               end
            end
            ST_PAUSE: begin
               if (start_ev_s) begin
                  state_nx = ST_RUN;
               end else begin
                  state_nx = ST_PAUSE;
               end
            end
            ST_DONE: begin
               state_nx = ST_DONE;
            end
            default: begin
               state_nx = ST_IDLE;
               ones_nx  = 4'd0;
               tens_nx  = 4'd0;
            end
         endcase
      end
   end

   // FSM register; status flags decode the next state so they move with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         ones_r    <= 4'd0;
         tens_r    <= 4'd0;
         dir_r     <= 1'b0;
         running_r <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_nx;
         ones_r    <= ones_nx;
         tens_r    <= tens_nx;
         dir_r     <= dir_nx;
         running_r <= (state_nx == ST_RUN);
         done_r    <= (state_nx == ST_DONE);
      end
   end

   assign wrap_s    = (mux_cnt_r == MW'(MUX_DIV - 1));
   assign slot_nx_s = wrap_s ? ~slot_r : slot_r;

   // Free-running digit scheduler; enables and digit are registered from the
   // next slot together, so there is never a blank or overlapping cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mux_cnt_r <= '0;
         slot_r    <= 1'b0;
         digit_r   <= 4'd0;
         en0_r     <= 1'b1;
         en1_r     <= 1'b0;
      end else begin
         mux_cnt_r <= wrap_s ? '0 : (mux_cnt_r + MW'(1));
         slot_r    <= slot_nx_s;
         digit_r   <= slot_nx_s ? tens_r : ones_r;
         en0_r     <= ~slot_nx_s;
         en1_r     <= slot_nx_s;
      end
   end

   assign ones    = ones_r;
   assign tens    = tens_r;
   assign digit   = digit_r;
   assign en0     = en0_r;
   assign en1     = en1_r;
   assign running = running_r;
   assign done    = done_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed bench for stopwatch_ctrl (DEB_CYCLES=4, MUX_DIV=4). The stimulus
// process pushes hand-computed expectations, tagged with the cycle they apply
// to, into a queue; a monitor process pops and compares them on the falling
// edge of that cycle.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic       pb_start;
   logic       pb_clear;
   logic       sw_load;
   logic       sw_dir;
   logic [3:0] preset;
   logic [3:0] ones;
   logic [3:0] tens;
   logic [3:0] digit;
   logic       en0;
   logic       en1;
   logic       running;
   logic       done;

   typedef struct {
      string      name;
      int         at;
      int         kind;   // 0 count/status, 1 display, 2 expired wait
      logic [3:0] o;
      logic [3:0] t;
      logic       r;
      logic       d;
      logic [3:0] dg;
      logic       e0;
      logic       e1;
   } exp_t;

   exp_t expq[$];
   int   cyc       = 0;
   int   errors    = 0;
   int   checks    = 0;
   bit   stim_done = 1'b0;

   stopwatch_ctrl #(.DEB_CYCLES(4), .MUX_DIV(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .pb_start(pb_start),
      .pb_clear(pb_clear),
      .sw_load (sw_load),
      .sw_dir  (sw_dir),
      .preset  (preset),
      .ones    (ones),
      .tens    (tens),
      .digit   (digit),
      .en0     (en0),
      .en1     (en1),
      .running (running),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp_cnt(input string name, input logic [3:0] o, input logic [3:0] t,
                          input logic r, input logic d);
      exp_t e;
      e.name = name; e.at = cyc; e.kind = 0;
      e.o = o; e.t = t; e.r = r; e.d = d;
      e.dg = 4'd0; e.e0 = 1'b0; e.e1 = 1'b0;
      expq.push_back(e);
   endtask

   task automatic exp_disp(input string name, input int ahead, input logic [3:0] dg,
                           input logic e0, input logic e1);
      exp_t e;
      e.name = name; e.at = cyc + ahead; e.kind = 1;
      e.o = 4'd0; e.t = 4'd0; e.r = 1'b0; e.d = 1'b0;
      e.dg = dg; e.e0 = e0; e.e1 = e1;
      expq.push_back(e);
   endtask

   task automatic exp_timeout(input string name);
      exp_t e;
      e.name = name; e.at = cyc; e.kind = 2;
      e.o = 4'd0; e.t = 4'd0; e.r = 1'b0; e.d = 1'b0;
      e.dg = 4'd0; e.e0 = 1'b0; e.e1 = 1'b0;
      expq.push_back(e);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         cycles(1);
         tick = 1'b0;
      end
   endtask

   // clean press: held long enough to debounce, then released and settled
   task automatic press_start();
      pb_start = 1'b1;
      cycles(10);
      pb_start = 1'b0;
      cycles(10);
   endtask

   task automatic press_clear();
      pb_clear = 1'b1;
      cycles(10);
      pb_clear = 1'b0;
      cycles(10);
   endtask

   // Monitor: compare every expectation due in the current cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (expq.size() > 0 && expq[0].at <= cyc) begin
            e = expq.pop_front();
            checks++;
            if (e.kind == 0) begin
               if ({ones, tens, running, done} !== {e.o, e.t, e.r, e.d}) begin
                  errors++;
                  $display("FAIL %s: got ones=%0d tens=%0d running=%0b done=%0b, want ones=%0d tens=%0d running=%0b done=%0b",
                           e.name, ones, tens, running, done, e.o, e.t, e.r, e.d);
               end
            end else if (e.kind == 1) begin
               if ({digit, en0, en1} !== {e.dg, e.e0, e.e1}) begin
                  errors++;
                  $display("FAIL %s: got digit=%0d en0=%0b en1=%0b, want digit=%0d en0=%0b en1=%0b",
                           e.name, digit, en0, en1, e.dg, e.e0, e.e1);
               end
            end else begin
               errors++;
               $display("FAIL %s: wait bound expired", e.name);
            end
         end
         if (stim_done) begin
            while (expq.size() > 0) begin
               e = expq.pop_front();
               checks++;
               errors++;
               $display("FAIL %s: expectation never reached", e.name);
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      bit found;
      bit prev;
      rst_n = 1'b0; tick = 1'b0; pb_start = 1'b0; pb_clear = 1'b0;
      sw_load = 1'b0; sw_dir = 1'b0; preset = 4'd0;
      cycles(3);
      exp_cnt("reset_cnt", 4'd0, 4'd0, 1'b0, 1'b0);
      exp_disp("reset_disp", 0, 4'd0, 1'b1, 1'b0);
      rst_n = 1'b1;
      cycles(2);

      // reach 37 in RUN, then reset asynchronously
      press_start();
      exp_cnt("start_run", 4'd0, 4'd0, 1'b1, 1'b0);
      ticks(37);
      exp_cnt("count_37", 4'd7, 4'd3, 1'b1, 1'b0);
      cycles(1);
      #1 rst_n = 1'b0;
      exp_cnt("async_reset_cnt", 4'd0, 4'd0, 1'b0, 1'b0);
      exp_disp("async_reset_disp", 0, 4'd0, 1'b1, 1'b0);
      cycles(2);
      rst_n = 1'b1;
      cycles(2);
      press_start();
      exp_cnt("restart_run", 4'd0, 4'd0, 1'b1, 1'b0);

      // count up 12, then to 99 and saturate
      ticks(12);
      exp_cnt("up_12", 4'd2, 4'd1, 1'b1, 1'b0);
      ticks(87);
      exp_cnt("up_99_done", 4'd9, 4'd9, 1'b0, 1'b1);
      ticks(3);
      exp_cnt("done_hold_99", 4'd9, 4'd9, 1'b0, 1'b1);
      press_start();
      exp_cnt("done_ignores_start", 4'd9, 4'd9, 1'b0, 1'b1);

      // clear, load preset 3 and count down to 00
      press_clear();
      exp_cnt("clear_from_done", 4'd0, 4'd0, 1'b0, 1'b0);
      sw_load = 1'b1; preset = 4'd3; sw_dir = 1'b1;
      cycles(2);
      exp_cnt("load_3", 4'd0, 4'd3, 1'b0, 1'b0);
      sw_load = 1'b0;
      press_start();
      exp_cnt("down_run", 4'd0, 4'd3, 1'b1, 1'b0);
      ticks(29);
      exp_cnt("down_01", 4'd1, 4'd0, 1'b1, 1'b0);
      ticks(1);
      exp_cnt("down_00_done", 4'd0, 4'd0, 1'b0, 1'b1);

      // preset clamp
      press_clear();
      sw_load = 1'b1; preset = 4'd12;
      cycles(2);
      exp_cnt("load_clamp_9", 4'd0, 4'd9, 1'b0, 1'b0);
      sw_load = 1'b0;

      // down start from 00 goes straight to DONE
      press_clear();
      press_start();
      exp_cnt("down_from_00_done", 4'd0, 4'd0, 1'b0, 1'b1);
      press_clear();
      sw_dir = 1'b0;

      // debounce: a 3-cycle bounce is ignored
      pb_start = 1'b1;
      cycles(3);
      pb_start = 1'b0;
      cycles(12);
      exp_cnt("bounce_ignored", 4'd0, 4'd0, 1'b0, 1'b0);

      // clean 10-cycle press: pulse after 6 edges, FSM moves on the 7th
      pb_start = 1'b1;
      cycles(6);
      exp_cnt("press_not_yet", 4'd0, 4'd0, 1'b0, 1'b0);
      cycles(1);
      exp_cnt("press_latency", 4'd0, 4'd0, 1'b1, 1'b0);
      cycles(3);
      pb_start = 1'b0;
      cycles(15);
      exp_cnt("single_event", 4'd0, 4'd0, 1'b1, 1'b0);

      // tick coinciding with a start press at 05
      ticks(5);
      exp_cnt("up_05", 4'd5, 4'd0, 1'b1, 1'b0);
      pb_start = 1'b1;
      cycles(6);
      tick = 1'b1;
      cycles(1);
      tick = 1'b0;
      exp_cnt("tick_and_pause", 4'd6, 4'd0, 1'b0, 1'b0);
      cycles(3);
      pb_start = 1'b0;
      cycles(10);
      ticks(5);
      exp_cnt("pause_holds", 4'd6, 4'd0, 1'b0, 1'b0);

      // clear and start together: clear wins
      pb_start = 1'b1; pb_clear = 1'b1;
      cycles(10);
      pb_start = 1'b0; pb_clear = 1'b0;
      cycles(10);
      exp_cnt("clear_beats_start", 4'd0, 4'd0, 1'b0, 1'b0);

      // build 47 and pause there
      sw_load = 1'b1; preset = 4'd4;
      cycles(2);
      sw_load = 1'b0;
      press_start();
      ticks(7);
      exp_cnt("count_47", 4'd7, 4'd4, 1'b1, 1'b0);
      press_start();
      exp_cnt("paused_47", 4'd7, 4'd4, 1'b0, 1'b0);

      // align to the start of a tens slot, then check three slots
      found = 1'b0;
      prev  = en1;
      for (int i = 0; i < 20; i++) begin
         cycles(1);
         if (en1 && !prev) begin
            found = 1'b1;
            break;
         end
         prev = en1;
      end
      if (found) begin
         for (int k = 0; k < 12; k++) begin
            if ((k / 4) % 2 == 0) begin
               exp_disp("mux_tens_slot", k, 4'd4, 1'b0, 1'b1);
            end else begin
               exp_disp("mux_ones_slot", k, 4'd7, 1'b1, 1'b0);
            end
         end
      end else begin
         exp_timeout("mux_slot_align");
      end
      cycles(13);

      cycles(2);
      stim_done = 1'b1;
   end

endmodule
